stage_sequencer: RTL
====================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 5, meaning the number of stage indicator bits (legal range 2..32).
REQ-002 The block SHALL have parameter WRAP, default 0, meaning 0 = saturate at the last stage and 1 = wrap to stage 0.
REQ-003 The block SHALL have parameter ONEHOT, default 0, meaning 0 = thermometer output and 1 = one-hot output.
REQ-004 The block SHALL have parameter HOLDOFF, default 0, meaning the number of cycles after an accepted event during which new edges are discarded (0..255).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clock and reset.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port advance, input, 1 bit: a synchronous level whose rising edge requests the next stage.
REQ-009 The block SHALL have port retreat, input, 1 bit: a synchronous level whose rising edge requests the previous stage.
REQ-010 The block SHALL have port clear, input, 1 bit: a synchronous level that returns the block to stage 0.
REQ-011 The block SHALL have port stageOut, output, NUM_STAGES bits: the stage indicator.
REQ-012 The block SHALL have port stageIdx, output, IDXW = clog2(NUM_STAGES+1) bits: the current stage count, 0..NUM_STAGES.
REQ-013 The block SHALL have port lastStage, output, 1 bit: high while stageIdx equals NUM_STAGES.
REQ-014 The block SHALL have port wrapped, output, 1 bit: a one-cycle pulse emitted on a wrap from NUM_STAGES to 0.
REQ-015 The block SHALL have port busy, output, 1 bit: high while the holdoff counter is nonzero.

Function
REQ-016 An edge SHALL be a sample of 1 at the current clock edge following a sample of 0 at the previous clock edge; the resulting stageIdx update SHALL be visible immediately after that same clock edge (1-cycle latency).
REQ-017 Event priority SHALL be: clear, then advance and retreat edges together (no change, both edges consumed, not accepted), then advance, then retreat.
REQ-018 An accepted advance below NUM_STAGES SHALL increment stageIdx by 1.
REQ-019 An advance at NUM_STAGES SHALL leave stageIdx unchanged if WRAP=0; if WRAP=1 it SHALL load 0 and pulse wrapped for one cycle.
REQ-020 A retreat at 0 SHALL leave stageIdx at 0 with no wrap; otherwise a retreat SHALL decrement stageIdx by 1.
REQ-021 In thermometer mode, stageOut[i] SHALL be 1 if and only if i < stageIdx.
REQ-022 In one-hot mode, stageOut[i] SHALL be 1 if and only if i == stageIdx-1, and stageOut SHALL be all zero at stageIdx 0.
REQ-023 Any accepted advance or retreat edge, including a saturated no-op, SHALL load the holdoff counter with HOLDOFF.
REQ-024 Edges arriving while busy=1 SHALL be discarded, not queued.
REQ-025 The holdoff counter SHALL decrement by 1 per cycle down to 0.
REQ-026 clear SHALL set stageIdx to 0, zero the holdoff counter, and suppress wrapped; it SHALL override a coincident edge.
REQ-027 The edge-detect history registers SHALL update every cycle, including during clear and while busy.
REQ-028 stageOut, lastStage and busy SHALL be decoded from registered state only, with no input-to-output combinational path.

Reset
REQ-029 While reset=0, stageIdx, stageOut, lastStage, wrapped, busy and the holdoff counter SHALL be 0.
REQ-030 While reset=0, the advance and retreat history registers SHALL be 1, so a level held high through reset release SHALL NOT produce an edge.
REQ-031 Reset asserted mid-holdoff or mid-wrap-pulse SHALL abort it immediately, with no residual pulse after release.

Structure
REQ-032 Package stage_pkg SHALL hold the IDXW width function, the WRAP and ONEHOT mode constants, and the HOLDOFF width constant.
REQ-033 Sub-module stage_edge_detect (1-bit rising-edge detector with reset value 1) SHALL be instantiated twice, once for advance and once for retreat.
REQ-034 The stage counter, holdoff counter and output decode SHALL remain in stage_sequencer.

Verification
REQ-035 With defaults, 6 advance pulses from reset SHALL give stageOut 00001, 00011, 00111, 01111, 11111, 11111, with lastStage=1 from pulse 5 onward.
REQ-036 With WRAP=1 and ONEHOT=1 at stageIdx=5, an advance SHALL give stageIdx=0, stageOut=00000 and a wrapped pulse exactly 1 cycle wide; a following advance SHALL give 00001.
REQ-037 At stageIdx=3, simultaneous rising edges on advance and retreat SHALL leave stageIdx=3; the same case with clear=1 SHALL give stageIdx=0.
REQ-038 With HOLDOFF=4, two advance edges 2 cycles apart SHALL give stageIdx=1, busy=1 for exactly 4 cycles, and a third edge at cycle 6 SHALL give stageIdx=2.
REQ-039 With advance held at 1 through reset release, stageIdx SHALL stay 0; reset asserted at stageIdx=4 with busy=1 SHALL zero all outputs asynchronously.
REQ-040 Retreat pulses at stageIdx=1 SHALL give stageIdx=0, and a further retreat SHALL leave stageIdx=0 with wrapped=0.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared types and constants for the stage sequencer: index width helper,
// mode encodings, holdoff counter width and the per-cycle event encoding.
package stage_pkg;

  localparam int WRAP_SATURATE = 0;
  localparam int WRAP_ROLL     = 1;
  localparam int MODE_THERMO   = 0;
  localparam int MODE_ONEHOT   = 1;
  localparam int HOLDOFF_W     = 8;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_CLEAR = 3'd1,
    EV_BOTH  = 3'd2,
    EV_ADV   = 3'd3,
    EV_RET   = 3'd4
  } stage_event_e;

  // Width able to hold a count from 0 up to and including n.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stage_edge_detect.sv
// One-bit rising-edge detector. History resets to 1 so a level held high
// across reset release is not mistaken for an edge.
module stage_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Sample history updates every cycle regardless of clear or holdoff.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/stage_sequencer.sv
// Stage counter driven by advance/retreat edges, with optional wrap,
// thermometer or one-hot indicator and a post-event holdoff window.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter  int NUM_STAGES = 5,
  parameter  int WRAP       = 0,
  parameter  int ONEHOT     = 0,
  parameter  int HOLDOFF    = 0,
  localparam int IDXW       = idx_width(NUM_STAGES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  retreat,
  input  logic                  clear,
  output logic [NUM_STAGES-1:0] stageOut,
  output logic [IDXW-1:0]       stageIdx,
  output logic                  lastStage,
  output logic                  wrapped,
  output logic                  busy
);

  localparam logic [IDXW-1:0]      LAST_IDX  = IDXW'(NUM_STAGES);
  localparam logic [IDXW-1:0]      ZERO_IDX  = {IDXW{1'b0}};
  localparam logic [IDXW-1:0]      ONE_IDX   = IDXW'(1);
  localparam logic [HOLDOFF_W-1:0] HOLD_LOAD = HOLDOFF_W'(HOLDOFF);
  localparam logic [HOLDOFF_W-1:0] HOLD_ZERO = {HOLDOFF_W{1'b0}};
  localparam logic [HOLDOFF_W-1:0] HOLD_ONE  = HOLDOFF_W'(1);

  logic                  adv_rise_s;
  logic                  ret_rise_s;
  stage_event_e          ev_s;
  logic [IDXW-1:0]       idx_q;
  logic [IDXW-1:0]       idx_d;
  logic [HOLDOFF_W-1:0]  hold_q;
  logic [HOLDOFF_W-1:0]  hold_d;
  logic                  wrap_d;
  logic                  wrapped_q;
  logic                  busy_q;
  logic                  last_q;
  logic [NUM_STAGES-1:0] stage_out_q;

  stage_edge_detect u_adv_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (advance),
    .rise_o (adv_rise_s)
  );

  stage_edge_detect u_ret_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (retreat),
    .rise_o (ret_rise_s)
  );

  function automatic logic [NUM_STAGES-1:0] decode_stage(input logic [IDXW-1:0] idx);
    logic [NUM_STAGES-1:0] out;
    out = {NUM_STAGES{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (ONEHOT == MODE_ONEHOT) begin
        out[i] = (int'(idx) == i + 1);
      end else begin
        out[i] = (i < int'(idx));
      end
    end
    return out;
  endfunction

  // Prioritise clear, then coincident edges, then advance, then retreat.
  // busy_q mirrors hold_q != 0, so edges seen during holdoff are dropped here.
  always_comb begin
    ev_s = EV_NONE;
    if (clear) begin
      ev_s = EV_CLEAR;
    end else if (!busy_q && adv_rise_s && ret_rise_s) begin
      ev_s = EV_BOTH;
    end else if (!busy_q && adv_rise_s) begin
      ev_s = EV_ADV;
    end else if (!busy_q && ret_rise_s) begin
      ev_s = EV_RET;
    end else begin
      ev_s = EV_NONE;
    end
  end

  // Next-state for the stage index, holdoff counter and wrap pulse.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (hold_q != HOLD_ZERO) begin
      hold_d = hold_q - HOLD_ONE;
    end else begin
      hold_d = HOLD_ZERO;
    end
    case (ev_s)
      EV_CLEAR: begin
        idx_d  = ZERO_IDX;
        hold_d = HOLD_ZERO;
      end
      EV_ADV: begin
        hold_d = HOLD_LOAD;
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + ONE_IDX;
        end else if (WRAP == WRAP_ROLL) begin
          idx_d  = ZERO_IDX;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q;
        end
      end
      EV_RET: begin
        hold_d = HOLD_LOAD;
        if (idx_q != ZERO_IDX) begin
          idx_d = idx_q - ONE_IDX;
        end else begin
          idx_d = idx_q;
        end
      end
      EV_BOTH, EV_NONE: begin
        idx_d = idx_q;
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  // State and decoded outputs all come straight from flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q       <= ZERO_IDX;
      hold_q      <= HOLD_ZERO;
      wrapped_q   <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b0;
      stage_out_q <= {NUM_STAGES{1'b0}};
    end else begin
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      wrapped_q   <= wrap_d;
      busy_q      <= (hold_d != HOLD_ZERO);
      last_q      <= (idx_d == LAST_IDX);
      stage_out_q <= decode_stage(idx_d);
    end
  end

  assign stageIdx  = idx_q;
  assign stageOut  = stage_out_q;
  assign lastStage = last_q;
  assign wrapped   = wrapped_q;
  assign busy      = busy_q;

endmodule
